data_mem_mmio: RTL

- Data-side memory subsystem that sits directly downstream of the pipelined core's M stage.
- Consumes memwrite/memaddr/memwritedata and returns memreaddata in the same cycle.
- Decodes each address to either a word-addressed data RAM or a small memory-mapped peripheral window: 32-bit timer with compare/interrupt, GPIO output register, synchronized GPIO input.

---
 rtl/data_mem_mmio_if.sv | 22 ++
 rtl/data_mem_mmio.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio_if.sv
// Data-side load/store bus between the core's M stage and the data memory subsystem.
// The core drives address/strobe/data; the memory returns read data in the same cycle.
interface data_mem_mmio_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;

    modport master (
        output memwrite,
        output memaddr,
        output memwritedata,
        input  memreaddata
    );

    modport slave (
        input  memwrite,
        input  memaddr,
        input  memwritedata,
        output memreaddata
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO window (timer with compare/irq, GPIO out, synchronized GPIO in).
// Loads are combinational from the current address; all state updates on posedge clk.
module data_mem_mmio #(
    parameter int          RAM_AW  = 10,
    parameter int          GPIO_W  = 8,
    parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_mmio_if.slave    bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);
    localparam logic [5:0] OFF_COUNT  = 6'd0;
    localparam logic [5:0] OFF_CMP    = 6'd1;
    localparam logic [5:0] OFF_CTRL   = 6'd2;
    localparam logic [5:0] OFF_STATUS = 6'd3;
    localparam logic [5:0] OFF_GOUT   = 6'd4;
    localparam logic [5:0] OFF_GIN    = 6'd5;

    logic              mmio_sel;
    logic [5:0]        offset;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_rdata;
    logic [31:0]       mmio_rdata;
    logic [31:0]       wdata;

    // Address bits outside the decoded fields alias by design.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.memaddr};

    assign mmio_sel = (bus.memaddr[31:16] == MMIO_HI);
    assign offset   = bus.memaddr[7:2];
    assign ram_idx  = bus.memaddr[RAM_AW+1:2];
    assign wdata    = bus.memwritedata;

    // RAM: asynchronous read, no reset so stores still land while reset is held.
    logic [31:0] ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (bus.memwrite && !mmio_sel)
            ram[ram_idx] <= wdata;
    end

    assign ram_rdata = ram[ram_idx];

    logic wr_count, wr_cmp, wr_ctrl, wr_status, wr_gout;
    assign wr_count  = bus.memwrite && mmio_sel && (offset == OFF_COUNT);
    assign wr_cmp    = bus.memwrite && mmio_sel && (offset == OFF_CMP);
    assign wr_ctrl   = bus.memwrite && mmio_sel && (offset == OFF_CTRL);
    assign wr_status = bus.memwrite && mmio_sel && (offset == OFF_STATUS);
    assign wr_gout   = bus.memwrite && mmio_sel && (offset == OFF_GOUT);

    logic [31:0]       count_reg, count_next;
    logic [31:0]       cmp_reg, cmp_next;
    logic              en_reg, en_next;
    logic              autoreload_reg, autoreload_next;
    logic              irqen_reg, irqen_next;
    logic [7:0]        presc_reg, presc_next;
    logic              match_reg, match_next;
    logic [7:0]        pcnt_reg, pcnt_next;
    logic [GPIO_W-1:0] gpio_out_reg, gpio_out_next;
    logic [GPIO_W-1:0] sync1_reg, sync2_reg;

    logic        tick;
    logic        hit;
    logic [31:0] count_inc;

    assign tick      = en_reg && (pcnt_reg == presc_reg);
    assign count_inc = count_reg + 32'd1;
    // A CPU write to COUNT suppresses the compare for that cycle.
    assign hit       = tick && !wr_count && (count_inc == cmp_reg);

    always_comb begin
        pcnt_next = pcnt_reg;
        if (wr_ctrl)
            pcnt_next = 8'd0;
        else if (en_reg)
            pcnt_next = tick ? 8'd0 : pcnt_reg + 8'd1;
    end

    always_comb begin
        count_next = count_reg;
        if (wr_count)
            count_next = wdata;
        else if (tick)
            count_next = (hit && autoreload_reg) ? 32'd0 : count_inc;
    end

    // Setting the match flag wins over a same-cycle write-1-to-clear.
    always_comb begin
        match_next = match_reg;
        if (hit)
            match_next = 1'b1;
        else if (wr_status && wdata[0])
            match_next = 1'b0;
    end

    always_comb begin
        cmp_next        = wr_cmp  ? wdata : cmp_reg;
        en_next         = wr_ctrl ? wdata[0]    : en_reg;
        autoreload_next = wr_ctrl ? wdata[1]    : autoreload_reg;
        irqen_next      = wr_ctrl ? wdata[2]    : irqen_reg;
        presc_next      = wr_ctrl ? wdata[15:8] : presc_reg;
        gpio_out_next   = wr_gout ? wdata[GPIO_W-1:0] : gpio_out_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            cmp_reg        <= '0;
            en_reg         <= 1'b0;
            autoreload_reg <= 1'b0;
            irqen_reg      <= 1'b0;
            presc_reg      <= '0;
            match_reg      <= 1'b0;
            pcnt_reg       <= '0;
            gpio_out_reg   <= '0;
            sync1_reg      <= '0;
            sync2_reg      <= '0;
        end else begin
            count_reg      <= count_next;
            cmp_reg        <= cmp_next;
            en_reg         <= en_next;
            autoreload_reg <= autoreload_next;
            irqen_reg      <= irqen_next;
            presc_reg      <= presc_next;
            match_reg      <= match_next;
            pcnt_reg       <= pcnt_next;
            gpio_out_reg   <= gpio_out_next;
            sync1_reg      <= gpio_in;
            sync2_reg      <= sync1_reg;
        end
    end

    always_comb begin
        mmio_rdata = 32'd0;
        case (offset)
            OFF_COUNT:  mmio_rdata = count_reg;
            OFF_CMP:    mmio_rdata = cmp_reg;
            OFF_CTRL:   mmio_rdata = {16'd0, presc_reg, 5'd0, irqen_reg, autoreload_reg, en_reg};
            OFF_STATUS: mmio_rdata = {31'd0, match_reg};
            OFF_GOUT:   mmio_rdata = 32'(gpio_out_reg);
            OFF_GIN:    mmio_rdata = 32'(sync2_reg);
            default:    mmio_rdata = 32'd0;
        endcase
    end

    assign bus.memreaddata = mmio_sel ? mmio_rdata : ram_rdata;
    assign gpio_out        = gpio_out_reg;
    assign timer_irq       = match_reg && irqen_reg;
endmodule
